dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
// - Memory-stage load/store responder; consumes the M/W control bundle (rd_en, wr_en) plus address, store data and funct3.
// - Runs a req/ack handshake with data memory and drives the pipeline stall while an access is outstanding.
// - Returns an aligned, sign/zero-extended load result for writeback, with an ack-timeout guard.
// PARAMETERS
// - AW           32   byte-address width
// - TIMEOUT_CYC  256  max cycles in REQ without mem_ack before abort (>=2)
// PORTS
// - clk          in   1   clock, rising edge
// - reset        in   1   reset, synchronous, active-high
// - rd_en        in   1   load request from M/W control
// - wr_en        in   1   store request from M/W control
// - funct3       in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - addr         in   AW  byte address
// - wdata        in   32  store data, LSB-justified
// - stall        out  1   hold pipeline (combinational)
// - rdata        out  32  extended load result
// - rdata_valid  out  1   1-cycle pulse: rdata valid (loads only)
// - bus_err      out  1   1-cycle pulse: access aborted by timeout
// - mis_trap     out  1   1-cycle pulse: misaligned access (see CONFIGURATION)
// - mem_req      out  1   bus request, held until mem_ack
// - mem_we       out  1   1 = write
// - mem_addr     out  AW  word-aligned address ([1:0] = 0)
// - mem_wdata    out  32  lane-replicated store data
// - mem_be       out  4   byte enables (all 0 for loads)
// - mem_ack      in   1   access complete; mem_rdata valid this cycle for loads
// - mem_rdata    in   32  raw read word
// BEHAVIOUR
// - Reset: state IDLE, counter 0; every registered output 0; stall = 0 while reset is high.
// - FSM IDLE -> REQ -> DONE -> IDLE.
//   - IDLE: on rd_en|wr_en, latch addr/wdata/funct3, compute be; go REQ.
//   - REQ: mem_req = 1. On mem_ack: capture mem_rdata, go DONE. No ack after TIMEOUT_CYC cycles in REQ: go DONE with error flag.
//   - DONE: stall = 0; pulse rdata_valid (load, no error) or bus_err; return to IDLE.
// - Requests are ignored in REQ and DONE. The pipeline advances on the DONE edge; the next instruction is sampled in IDLE.
// - stall = (IDLE & (rd_en|wr_en)) | REQ.
// - Latency: ack in first REQ cycle gives 2 stall cycles; each extra wait cycle adds 1.
// - rd_en & wr_en both high: store performed, load ignored (no rdata_valid).
// - mem_addr, mem_we, mem_wdata and mem_be are stable for the whole of REQ. mem_req falls on the edge after ack.
// - Byte enables:
//   - B/BU: 0001 << addr[1:0]
//   - H/HU: 0011 << {addr[1],1'b0}
//   - W and undefined funct3 (011, 110, 111): 1111
// - Store data: wdata[7:0] replicated x4 (byte) or wdata[15:0] x2 (half).
// - Load: select lane per addr[1:0]; B/H sign-extend, BU/HU zero-extend; W passes through.
// - rdata holds its value until the next load completes. On timeout, rdata = 0.
// - Timeout counter width $clog2(TIMEOUT_CYC+1); clears on entry to REQ; saturates, no wrap.
// - Reset mid-access: FSM to IDLE, mem_req 0 on the next edge; any later mem_ack in IDLE is ignored.
// CONFIGURATION
// - MISALIGN_TRAP_EN defined:
//   - Misaligned access (H with addr[0]=1; W with addr[1:0]!=0) skips REQ: IDLE -> DONE, no mem_req.
//   - stall high 1 cycle; mis_trap pulses in DONE; rdata unchanged.
// - MISALIGN_TRAP_EN undefined:
//   - Offending low address bits are dropped (natural alignment forced); access proceeds normally.
//   - mis_trap tied 0.
// TESTING
// - SW addr=0x100 wdata=0xDEADBEEF, ack 2 cycles after req -> mem_addr=0x100, be=1111, mem_we=1, stall high 3 cycles, one request.
// - LB addr=0x103, mem_rdata=0x80FF0000 -> rdata=0xFFFFFF80, rdata_valid pulse. LBU same -> 0x00000080.
// - SH addr=0x202 wdata=0x00001234 -> be=1100, mem_wdata=0x12341234.
// - Load, mem_ack never asserted -> stall high TIMEOUT_CYC+1 cycles, bus_err 1-cycle pulse, rdata=0, mem_req low after.
// - reset asserted in REQ, ack 1 cycle later -> mem_req=0, stall=0, no rdata_valid, state IDLE.
// - LW addr=0x102 -> with MISALIGN_TRAP_EN: mis_trap pulse, no mem_req. Without: mem_addr=0x100, normal load.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Memory-stage load/store controller: req/ack handshake with data memory, pipeline stall,
// load lane extraction/extension and ack timeout. Optional macro MISALIGN_TRAP_EN traps misaligned accesses.
module dmem_access_ctrl #(
  parameter int AW          = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_en,
  input  logic          wr_en,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic          stall,
  output logic [31:0]   rdata,
  output logic          rdata_valid,
  output logic          bus_err,
  output logic          mis_trap,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ld_q, ld_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rv_q, rv_d;
  logic            err_q, err_d;
  logic            mt_q, mt_d;

  logic [1:0]      off;
  logic [3:0]      be;
  logic [31:0]     wrep;
  logic [31:0]     lane;
  logic [31:0]     ext;
`ifdef MISALIGN_TRAP_EN
  logic            mis;
`endif

  // Byte offset with natural alignment forced for halves and words.
  always_comb begin
    off  = 2'b00;
    be   = 4'b1111;
    wrep = wdata;
    case (funct3[1:0])
      2'b00: begin off = addr[1:0];         be = 4'b0001 << off; wrep = {4{wdata[7:0]}};  end
      2'b01: begin off = {addr[1], 1'b0};   be = 4'b0011 << off; wrep = {2{wdata[15:0]}}; end
      default: ;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign mis = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`endif

  assign lane = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ext = {24'h0, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ext = {16'h0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    f3_d    = f3_q;
    off_d   = off_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    mt_d    = 1'b0;
    case (state_q)
      IDLE: if (rd_en | wr_en) begin
        f3_d    = funct3;
        off_d   = off;
        ld_d    = rd_en & ~wr_en;
        we_d    = wr_en;
        addr_d  = {addr[AW-1:2], 2'b00};
        wdata_d = wrep;
        be_d    = wr_en ? be : 4'b0000;
        cnt_d   = '0;
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
          state_d = DONE;
          mt_d    = 1'b1;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
        end
`else
        state_d = REQ;
        req_d   = 1'b1;
`endif
      end
      REQ: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (ld_q) begin
            rdata_d = ext;
            rv_d    = 1'b1;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          req_d   = 1'b0;
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ld_q    <= 1'b0;
      f3_q    <= 3'b0;
      off_q   <= 2'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0;
      rdata_q <= 32'h0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      mt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      mt_q    <= mt_d;
    end
  end

  assign stall       = ~reset & (((state_q == IDLE) & (rd_en | wr_en)) | (state_q == REQ));
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rv_q;
  assign bus_err     = err_q;
`ifdef MISALIGN_TRAP_EN
  assign mis_trap    = mt_q;
`else
  assign mis_trap    = 1'b0;
`endif

endmodule
